// File: rtl/lsu_align.sv
// Load/store alignment unit: one word-aligned bus access per start, load data right-justified, store lanes replicated.
// Latency: start -> mem_req next cycle; mem_ack -> done next cycle; illegal/misaligned start -> done+err next cycle.
// Backpressure: mem_req held until mem_ack or timeout; start ignored (not queued) while busy.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, is_store,    access request; size/addr/wdata captured when start is seen in IDLE
//   size, addr, wdata
//   busy, done, err     status; done is a one-cycle pulse, err only valid with done
//   rdata_aligned       right-justified zero-filled load data, held until the next successful load
//   mem_*               word-aligned memory bus (req/ack handshake, read data valid with ack)
module lsu_align #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata_aligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Wide enough to hold TIMEOUT_CYCLES-1 for any legal TIMEOUT_CYCLES >= 1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic [31:0]   rdata_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wdata_q;

  logic          legal;
  logic          expire;
  logic [3:0]    be_calc;
  logic [31:0]   wd_calc;
  logic [31:0]   load_calc;

  // Access legality of the request presented with start.
  always_comb begin
    legal = 1'b1;
    case (size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~addr[0];
      2'b10:   legal = (addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated write data for the request presented with start.
  always_comb begin
    be_calc = 4'b1111;
    wd_calc = 32'h0;
    if (is_store) begin
      case (size)
        2'b00: begin
          be_calc = 4'b0001 << addr[1:0];
          wd_calc = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_calc = addr[1] ? 4'b1100 : 4'b0011;
          wd_calc = {2{wdata[15:0]}};
        end
        default: begin
          be_calc = 4'b1111;
          wd_calc = wdata;
        end
      endcase
    end
  end

  // Lane extraction of returning read data, using the offset/size captured at start.
  always_comb begin
    load_calc = mem_rdata;
    case (size_q)
      2'b00: begin
        case (off_q)
          2'd0:    load_calc = {24'h0, mem_rdata[7:0]};
          2'd1:    load_calc = {24'h0, mem_rdata[15:8]};
          2'd2:    load_calc = {24'h0, mem_rdata[23:16]};
          default: load_calc = {24'h0, mem_rdata[31:24]};
        endcase
      end
      2'b01:   load_calc = off_q[1] ? {16'h0, mem_rdata[31:16]} : {16'h0, mem_rdata[15:0]};
      default: load_calc = mem_rdata;
    endcase
  end

  // Last permitted REQ cycle without an acknowledge.
  assign expire = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    mem_req = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = legal ? S_REQ : S_DONE;
      end
      S_REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        // An ack on the expiry cycle still completes the access successfully.
        if (mem_ack || expire) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      err_q       <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      rdata_q     <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          err_q <= 1'b0;
          if (start) begin
            if (legal) begin
              cnt_q       <= '0;
              off_q       <= addr[1:0];
              size_q      <= size;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_be_q    <= be_calc;
              mem_wdata_q <= wd_calc;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_ack || expire) begin
            err_q       <= ~mem_ack;
            // Bus fields are only meaningful while the request is up.
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            if (mem_ack && !mem_we_q) rdata_q <= load_calc;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          err_q <= err_q;
        end
      endcase
    end
  end

  assign rdata_aligned = rdata_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_lsu_align.sv
module tb_lsu_align;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata_aligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int accepted = 0;
  logic [31:0] model_rdata = 32'h0;

  always #5 clk = ~clk;

  lsu_align #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .size(size),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata_aligned(rdata_aligned), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference rules, written directly from the access definition.
  function automatic bit ref_legal(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 0;
    if (sz == 2'd1) return (a % 2) == 0;
    if (sz == 2'd2) return (a % 4) == 0;
    return 1;
  endfunction

  function automatic logic [3:0] ref_be(input bit st, input logic [1:0] sz, input logic [31:0] a);
    if (!st || sz == 2'd2) return 4'hF;
    if (sz == 2'd0) return 4'(1 << (a % 4));
    return 4'(3 << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wd(input bit st, input logic [1:0] sz, input logic [31:0] w);
    if (!st) return 32'h0;
    if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * (a % 4));
    if (sz == 2'd0) return sh & 32'hFF;
    if (sz == 2'd1) return sh & 32'hFFFF;
    return rd;
  endfunction

  // One access; ack_at = REQ cycle index (0-based) carrying mem_ack, or -1 for none.
  task automatic access(input string tag, input bit st, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] rd, input int ack_at);
    bit acked;
    int req_cycles;
    start = 1'b1; is_store = st; size = sz; addr = a; wdata = w;
    step();
    accepted++;
    // Scramble captured inputs; they must no longer matter.
    start = 1'b0; is_store = $urandom; size = 2'($urandom); addr = $urandom; wdata = $urandom;
    acked = 0;
    req_cycles = 0;
    if (!ref_legal(sz, a)) begin
      chk({tag, ".ill_req"}, 32'(mem_req), 32'd0);
      chk({tag, ".ill_done"}, 32'(done), 32'd1);
      chk({tag, ".ill_err"}, 32'(err), 32'd1);
    end else begin
      for (int k = 0; k < TO; k++) begin
        chk({tag, ".req"}, 32'(mem_req), 32'd1);
        chk({tag, ".addr"}, mem_addr, a & 32'hFFFF_FFFC);
        chk({tag, ".we"}, 32'(mem_we), 32'(st));
        chk({tag, ".be"}, 32'(mem_be), 32'(ref_be(st, sz, a)));
        chk({tag, ".wd"}, mem_wdata, ref_wd(st, sz, w));
        chk({tag, ".nodone"}, 32'(done), 32'd0);
        req_cycles++;
        start = $urandom;
        if (k == ack_at) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
          acked = 1;
        end else begin
          mem_rdata = $urandom;
        end
        step();
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (acked) break;
      end
      if (acked && !st) model_rdata = ref_load(sz, a, rd);
      if (!acked) chk({tag, ".req_cycles"}, 32'(req_cycles), 32'(TO));
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".err"}, 32'(err), 32'(!acked));
      chk({tag, ".req_off"}, 32'(mem_req), 32'd0);
    end
    chk({tag, ".rdata"}, rdata_aligned, model_rdata);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    start = $urandom;
    step();
    start = 1'b0;
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
    chk({tag, ".idle_err"}, 32'(err), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0] rsz;
    logic [31:0] ra;
    reset = 1'b1; start = 1'b0; is_store = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    step();
    step();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.addr", mem_addr, 32'h0);
    chk("rst.be", 32'(mem_be), 32'd0);
    chk("rst.rdata", rdata_aligned, 32'h0);
    reset = 1'b0;
    step();

    access("lb", 0, 2'd0, 32'h1003, 32'h0, 32'hAABBCCDD, 0);
    chk("lb.val", rdata_aligned, 32'h000000AA);
    access("lh", 0, 2'd1, 32'h2002, 32'h0, 32'h8001_7FFF, 3);
    chk("lh.val", rdata_aligned, 32'h00008001);
    access("sh", 1, 2'd1, 32'h2006, 32'h1234ABCD, 32'hDEADBEEF, 1);
    access("misw", 0, 2'd2, 32'h3001, 32'h0, 32'h0, 0);
    access("illsz", 1, 2'd3, 32'h4000, 32'h55, 32'h0, 0);
    access("tmo", 0, 2'd2, 32'h5000, 32'h0, 32'h11111111, -1);
    access("tmo_ack", 0, 2'd2, 32'h5004, 32'h0, 32'h22223333, TO - 1);
    chk("tmo_ack.val", rdata_aligned, 32'h22223333);

    for (int i = 0; i < 40; i++) begin
      rsz = 2'($urandom);
      ra = $urandom;
      // Bias toward legal alignment so most accesses reach the bus.
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'd1) ra[0] = 1'b0;
        if (rsz == 2'd2) ra[1:0] = 2'b00;
      end
      access("rnd", 1'($urandom), rsz, ra, $urandom, $urandom,
             ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO - 1)));
    end

    // Reset in the middle of a request; a late ack must have no effect.
    start = 1'b1; is_store = 1'b0; size = 2'd2; addr = 32'h40; wdata = 32'h0;
    step();
    start = 1'b0;
    chk("mid.req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    step();
    model_rdata = 32'h0;
    reset = 1'b0;
    chk("mid.req_off", 32'(mem_req), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.addr", mem_addr, 32'h0);
    chk("mid.rdata", rdata_aligned, model_rdata);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    chk("late.done", 32'(done), 32'd0);
    chk("late.req", 32'(mem_req), 32'd0);
    chk("late.rdata", rdata_aligned, model_rdata);
    step();
    chk("late.done2", 32'(done), 32'd0);

    chk("done_count", 32'(done_cnt), 32'(accepted));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
